// File: rtl/dht_sensor_ctrl_if.sv
// Request/result bundle between dht_sensor_ctrl and its client (start/mode in, status and results out).
// The requester uses the master modport; the controller uses the slave modport.
interface dht_sensor_ctrl_if;
  logic        i_start;
  logic        i_mode;
  logic        o_busy;
  logic        o_done;
  logic        o_valid;
  logic        o_err_to;
  logic        o_err_csum;
  logic [1:0]  o_retry_cnt;
  logic [15:0] humid;
  logic [15:0] temp;
  logic [3:0]  o_state;

  modport master (
    output i_start, i_mode,
    input  o_busy, o_done, o_valid, o_err_to, o_err_csum, o_retry_cnt, humid, temp, o_state
  );

  modport slave (
    input  i_start, i_mode,
    output o_busy, o_done, o_valid, o_err_to, o_err_csum, o_retry_cnt, humid, temp, o_state
  );
endinterface

// File: rtl/dht_sensor_ctrl.sv
// Open-drain single-wire DHT11/DHT22 reader with per-phase timeouts, checksum and signed DHT22 decode.
// Optional feature macro: DHT_AUTO_RETRY_EN (automatic retries with a bus-idle gap between attempts).
module dht_sensor_ctrl #(
  parameter int START_LOW_US  = 18000,
  parameter int RESP_TO_US    = 200,
  parameter int BIT_THRESH_US = 40,
  parameter int RETRY_MAX     = 3,
  parameter int RETRY_GAP_US  = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  inout  wire               dht_io,
  dht_sensor_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RESP_WAIT = 4'd2,
    S_RESP_L    = 4'd3,
    S_RESP_H    = 4'd4,
    S_BIT_L     = 4'd5,
    S_BIT_H     = 4'd6,
    S_CHECK     = 4'd7,
    S_GAP       = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  localparam int CNT_MAX_A = (START_LOW_US > RETRY_GAP_US) ? START_LOW_US : RETRY_GAP_US;
  localparam int CNT_MAX   = (CNT_MAX_A > RESP_TO_US + 1) ? CNT_MAX_A : RESP_TO_US + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0] C_START = CNT_W'(START_LOW_US);
  localparam logic [CNT_W-1:0] C_TO    = CNT_W'(RESP_TO_US);
  localparam logic [CNT_W-1:0] C_THR   = CNT_W'(BIT_THRESH_US);
  localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(RETRY_GAP_US);
  localparam logic [1:0]       RETRY_LIM = 2'(RETRY_MAX);

`ifdef DHT_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1, r_sync2, r_sync3;
  logic             r_oe;
  logic [39:0]      r_data;
  logic [5:0]       r_bit;
  logic             r_mode;
  logic [1:0]       r_retry_cnt;
  logic             r_valid, r_err_to, r_err_csum;
  logic [15:0]      r_humid, r_temp;

  logic             w_rise, w_fall, w_timeout, w_bit_val;
  logic             w_fail_to, w_fail_csum, w_can_retry, w_csum_ok;
  logic [7:0]       w_sum;

  // Sign-magnitude DHT22 temperature (bit 15 = negative) to two's complement.
  function automatic logic [15:0] f_dht22_temp(input logic [7:0] hi, input logic [7:0] lo);
    logic signed [15:0] mag;
    mag = signed'({1'b0, hi[6:0], lo});
    return hi[7] ? $unsigned(-mag) : {hi, lo};
  endfunction

  // The controller only ever pulls low; the external pull-up provides the high level.
  assign dht_io = r_oe ? 1'b0 : 1'bz;

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_fall      = ~r_sync2 & r_sync3;
  assign w_timeout   = (r_cnt > C_TO);
  assign w_bit_val   = (r_cnt > C_THR);
  assign w_sum       = r_data[39:32] + r_data[31:24] + r_data[23:16] + r_data[15:8];
  assign w_csum_ok   = (w_sum == r_data[7:0]);
  assign w_can_retry = RETRY_EN && (r_retry_cnt < RETRY_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= dht_io;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Wait states look for edges, so the stale low left in the synchroniser after
  // the host releases the line is not mistaken for the sensor's response.
  always_comb begin
    w_next      = r_state;
    w_fail_to   = 1'b0;
    w_fail_csum = 1'b0;
    unique case (r_state)
      S_IDLE:      if (bus.i_start) w_next = S_START_LOW;
      S_START_LOW: if (r_cnt >= C_START) w_next = S_RESP_WAIT;
      S_RESP_WAIT: if (w_fall) w_next = S_RESP_L; else if (w_timeout) w_fail_to = 1'b1;
      S_RESP_L:    if (w_rise) w_next = S_RESP_H; else if (w_timeout) w_fail_to = 1'b1;
      S_RESP_H:    if (w_fall) w_next = S_BIT_L;  else if (w_timeout) w_fail_to = 1'b1;
      S_BIT_L:     if (w_rise) w_next = S_BIT_H;  else if (w_timeout) w_fail_to = 1'b1;
      S_BIT_H: begin
        if (w_fall)         w_next = (r_bit == 6'd39) ? S_CHECK : S_BIT_L;
        else if (w_timeout) w_fail_to = 1'b1;
      end
      S_CHECK:     if (w_csum_ok) w_next = S_DONE; else w_fail_csum = 1'b1;
`ifdef DHT_AUTO_RETRY_EN
      S_GAP:       if (r_cnt >= C_GAP) w_next = S_START_LOW;
`else
      S_GAP:       w_next = S_IDLE;
`endif
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_fail_to || w_fail_csum) w_next = w_can_retry ? S_GAP : S_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_oe    <= 1'b0;
      r_bit   <= '0;
    end else begin
      r_state <= w_next;
      r_oe    <= (w_next == S_START_LOW);
      if (w_next != r_state)       r_cnt <= '0;
      else if (i_tick && r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
      if (w_next == S_START_LOW)   r_bit <= '0;
      else if (r_state == S_BIT_H && w_fall) r_bit <= r_bit + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_BIT_H && w_fall) r_data <= {r_data[38:0], w_bit_val};
  end

  // Results and flags only change on an accepted start or when a transaction ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode      <= 1'b0;
      r_retry_cnt <= '0;
      r_valid     <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_csum  <= 1'b0;
      r_humid     <= '0;
      r_temp      <= '0;
    end else begin
      if (r_state == S_IDLE && bus.i_start) begin
        r_mode      <= bus.i_mode;
        r_retry_cnt <= '0;
        r_valid     <= 1'b0;
        r_err_to    <= 1'b0;
        r_err_csum  <= 1'b0;
      end
      if (w_fail_to || w_fail_csum) begin
        if (w_can_retry) begin
          r_retry_cnt <= r_retry_cnt + 1'b1;
        end else begin
          r_err_to   <= w_fail_to;
          r_err_csum <= w_fail_csum;
        end
      end
      if (r_state == S_CHECK && w_csum_ok) begin
        r_valid <= 1'b1;
        r_humid <= r_data[39:24];
        r_temp  <= r_mode ? f_dht22_temp(r_data[23:16], r_data[15:8]) : r_data[23:8];
      end
    end
  end

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = (r_state == S_DONE);
  assign bus.o_valid     = r_valid;
  assign bus.o_err_to    = r_err_to;
  assign bus.o_err_csum  = r_err_csum;
  assign bus.o_retry_cnt = r_retry_cnt;
  assign bus.humid       = r_humid;
  assign bus.temp        = r_temp;
  assign bus.o_state     = r_state;

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Scoreboard bench for dht_sensor_ctrl: a behavioural sensor drives the open-drain line,
// expected results are queued at stimulus time and compared on every o_done pulse.
module tb_dht_sensor_ctrl;
  localparam int START_LOW_US  = 60;
  localparam int RESP_TO_US    = 200;
  localparam int BIT_THRESH_US = 40;
  localparam int RETRY_MAX     = 3;
  localparam int RETRY_GAP_US  = 100;
`ifdef DHT_AUTO_RETRY_EN
  localparam logic [1:0] EXP_RETRY = 2'd3;
  localparam int         N_ATTEMPT = 4;
`else
  localparam logic [1:0] EXP_RETRY = 2'd0;
  localparam int         N_ATTEMPT = 1;
`endif

  typedef struct packed {
    logic [15:0] humid;
    logic [15:0] temp;
    logic        valid;
    logic        err_to;
    logic        err_csum;
    logic [1:0]  retry;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  i_tick;
  logic  sens_low;
  wire   dht_io;
  int    n_chk = 0;
  int    n_err = 0;
  exp_t  sb_q[$];
  logic [15:0] m_humid = 16'h0;
  logic [15:0] m_temp  = 16'h0;

  dht_sensor_ctrl_if bus ();

  dht_sensor_ctrl #(
    .START_LOW_US (START_LOW_US),
    .RESP_TO_US   (RESP_TO_US),
    .BIT_THRESH_US(BIT_THRESH_US),
    .RETRY_MAX    (RETRY_MAX),
    .RETRY_GAP_US (RETRY_GAP_US)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .i_tick (i_tick),
    .dht_io (dht_io),
    .bus    (bus)
  );

  assign dht_io = sens_low ? 1'b0 : 1'bz;
  pullup (dht_io);

  always #5 clk = ~clk;

  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      i_tick = ~i_tick;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] h, input logic [15:0] t, input logic v,
                          input logic eto, input logic ecs, input logic [1:0] r);
    exp_t e;
    e.humid = h; e.temp = t; e.valid = v; e.err_to = eto; e.err_csum = ecs; e.retry = r;
    sb_q.push_back(e);
    if (v) begin
      m_humid = h;
      m_temp  = t;
    end
  endtask

  // Waits n tick cycles, then returns at the following falling clock edge.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!i_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_line(input logic v, input int budget, input string tag);
    int n = 0;
    while (dht_io !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, dht_io, v);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.o_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, bus.o_busy, 1'b0);
  endtask

  task automatic do_start(input logic mode);
    @(negedge clk);
    bus.i_mode  = mode;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_mode  = ~mode;
    check_eq("start_busy", bus.o_busy, 1'b1);
    check_eq("start_oe", dht_io, 1'b0);
  endtask

  task automatic sensor_frame(input logic [39:0] d, input int hi0, input int hi1,
                              input int resp_l, input int stop_bit);
    wait_line(1'b0, 4000, "host_low");
    wait_line(1'b1, 4000, "host_rel");
    hold(30);
    sens_low = 1'b1; hold(resp_l);
    sens_low = 1'b0; hold(80);
    for (int k = 0; k < 40; k++) begin
      sens_low = 1'b1; hold(30);
      sens_low = 1'b0;
      if (k == stop_bit) begin
        hold(10);
        return;
      end
      hold(d[39-k] ? hi1 : hi0);
    end
    sens_low = 1'b1; hold(30);
    sens_low = 1'b0;
  endtask

  task automatic poke_in_bith(input int nth);
    int seen = 0;
    int guard = 0;
    logic [3:0] prev = 4'd0;
    while (seen < nth && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (bus.o_state == 4'd6 && prev != 4'd6) seen++;
      prev = bus.o_state;
    end
    check_eq("poke_reach", seen, nth);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check_eq("poke_state", bus.o_state, 4'd6);
    check_eq("poke_busy", bus.o_busy, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  bus.o_busy, 1'b0);
    check_eq({tag, "_done"},  bus.o_done, 1'b0);
    check_eq({tag, "_valid"}, bus.o_valid, 1'b0);
    check_eq({tag, "_eto"},   bus.o_err_to, 1'b0);
    check_eq({tag, "_ecs"},   bus.o_err_csum, 1'b0);
    check_eq({tag, "_retry"}, bus.o_retry_cnt, 2'd0);
    check_eq({tag, "_humid"}, bus.humid, 16'h0);
    check_eq({tag, "_temp"},  bus.temp, 16'h0);
    check_eq({tag, "_state"}, bus.o_state, 4'd0);
    check_eq({tag, "_line"},  dht_io, 1'b1);
  endtask

  // Output side of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("done_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("humid",    bus.humid, e.humid);
          check_eq("temp",     bus.temp, e.temp);
          check_eq("valid",    bus.o_valid, e.valid);
          check_eq("err_to",   bus.o_err_to, e.err_to);
          check_eq("err_csum", bus.o_err_csum, e.err_csum);
          check_eq("retry",    bus.o_retry_cnt, e.retry);
          check_eq("busy_at_done", bus.o_busy, 1'b1);
        end
        @(negedge clk);
        check_eq("busy_fall", bus.o_busy, 1'b0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: time %0t reached the simulation limit", $time);
    $fatal(1, "simulation limit reached");
  end

  initial begin
    int nt;
    int guard;
    rst = 1'b0; sens_low = 1'b0; bus.i_start = 1'b0; bus.i_mode = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // DHT11 frame
    push_exp(16'h3700, 16'h1805, 1'b1, 1'b0, 1'b0, 2'd0);
    do_start(1'b0);
    sensor_frame(40'h37_00_18_05_54, 26, 70, 80, -1);
    wait_idle("idle_dht11", 5000);

    // DHT22 negative temperature, mode toggled mid-transaction by do_start
    push_exp(16'h028C, 16'hFF9B, 1'b1, 1'b0, 1'b0, 2'd0);
    do_start(1'b1);
    sensor_frame(40'h02_8C_80_65_73, 26, 70, 80, -1);
    wait_idle("idle_dht22", 5000);

    // Corrupted checksum keeps the previous good result
    push_exp(m_humid, m_temp, 1'b0, 1'b0, 1'b1, EXP_RETRY);
    do_start(1'b0);
    for (int a = 0; a < N_ATTEMPT; a++) sensor_frame(40'h37_00_18_05_55, 26, 70, 80, -1);
    wait_idle("idle_csum", 5000);

    // Silent sensor
    push_exp(m_humid, m_temp, 1'b0, 1'b1, 1'b0, EXP_RETRY);
    do_start(1'b1);
`ifndef DHT_AUTO_RETRY_EN
    wait_line(1'b1, 4000, "to_rel");
    nt = 0;
    guard = 0;
    while (bus.o_done !== 1'b1 && guard < 2000) begin
      @(posedge clk);
      if (i_tick) nt++;
      @(negedge clk);
      guard++;
    end
    check_eq("to_ticks", nt, 201);
`endif
    wait_idle("idle_to", 8000);

    // 40/41-tick bit widths, 200-tick response phase, start pulse inside BIT_H
    push_exp(16'hA50F, 16'h33C3, 1'b1, 1'b0, 1'b0, 2'd0);
    do_start(1'b0);
    fork
      sensor_frame(40'hA5_0F_33_C3_AA, 40, 41, 200, -1);
      poke_in_bith(10);
    join
    wait_idle("idle_edge", 5000);
    repeat (20) @(negedge clk);
    check_eq("no_restart", bus.o_busy, 1'b0);

    // Reset while the host drives the start pulse
    do_start(1'b0);
    repeat (5) @(negedge clk);
    check_eq("sl_drive", dht_io, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("sl_release", dht_io, 1'b1);
    check_eq("sl_busy", bus.o_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame to repopulate results, then reset during bit 20
    push_exp(16'h0123, 16'h4567, 1'b1, 1'b0, 1'b0, 2'd0);
    do_start(1'b0);
    sensor_frame(40'h01_23_45_67_D0, 26, 70, 80, -1);
    wait_idle("idle_pre", 5000);
    do_start(1'b0);
    sensor_frame(40'h01_23_45_67_D0, 26, 70, 80, 20);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst20");
    @(negedge clk);
    rst = 1'b1;
    m_humid = 16'h0;
    m_temp  = 16'h0;
    repeat (3) @(negedge clk);

    // Clean DHT22 transaction after reset
    push_exp(16'h01F4, 16'h00FA, 1'b1, 1'b0, 1'b0, 2'd0);
    do_start(1'b1);
    sensor_frame(40'h01_F4_00_FA_EF, 26, 70, 80, -1);
    wait_idle("idle_clean", 5000);
    repeat (4) @(negedge clk);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
